// File: rtl/transform_stream_walker_if.sv
// transform_stream_walker_if: character-pair output stream with backpressure and last-beat marker
interface transform_stream_walker_if #(
  parameter int CHAR_W = 8
) ();
  logic              out_valid;
  logic              out_ready;
  logic [CHAR_W-1:0] lhs;
  logic [CHAR_W-1:0] rhs;
  logic              out_last;
  modport master(output out_valid, lhs, rhs, out_last, input out_ready);
  modport slave(input out_valid, lhs, rhs, out_last, output out_ready);
endinterface

// File: rtl/transform_stream_walker.sv
// transform_stream_walker: looks up {len,start} for a line, then streams len char pairs with backpressure
module transform_stream_walker #(
  parameter int CHAR_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int LEN_W     = 8,
  parameter int LINE_W    = 8,
  parameter int NUM_LINES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LINE_W-1:0]       line,
  output logic                    busy,
  output logic [LINE_W-1:0]       lt_addr,
  input  logic [LEN_W+ADDR_W-1:0] lt_data,
  output logic                    mem_en,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [2*CHAR_W-1:0]     mem_dout,
  transform_stream_walker_if.master os,
  output logic                    done,
  output logic                    err
);
  localparam int SW = (LEN_W > ADDR_W ? LEN_W : ADDR_W) + 1;
  typedef enum logic [2:0] {IDLE, LUT_REQ, LUT_CAP, STREAM, DRAIN} state_t;
  state_t state, state_nx;
  logic [LEN_W-1:0]          len_q, issue_cnt, beat_cnt, lt_len;
  logic [ADDR_W-1:0]         lt_start;
  logic [SW-1:0]             end_addr;
  logic [1:0][2*CHAR_W-1:0]  fifo;
  logic [1:0]                count;
  logic [2:0]                occ;
  logic                      rd_ptr, wr_ptr, inflight, done_nx, err_nx, bad, pop, last_issue, accept;
  assign {lt_len, lt_start} = lt_data;
  assign end_addr = SW'(lt_len) + SW'(lt_start);
  assign bad = 32'(lt_addr) >= 32'(NUM_LINES) || end_addr > (SW'(1) << ADDR_W);
  // a start arriving in the done cycle is dropped, as if the walk were still busy
  assign accept = state == IDLE && start && !done;
  assign busy = state != IDLE;
  assign os.out_valid = count != 2'd0;
  assign {os.lhs, os.rhs} = fifo[rd_ptr];
  assign os.out_last = os.out_valid && beat_cnt == len_q - LEN_W'(1);
  assign pop = os.out_valid && os.out_ready;
  // occupancy after this cycle's pop; a read is issued only if its data is sure to fit
  assign occ = 3'(count) + 3'(inflight) - 3'(pop);
  assign last_issue = issue_cnt == len_q - LEN_W'(1);
  assign mem_en = state == STREAM && occ < 3'd2;
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    done_nx = 1'b0;
    err_nx = 1'b0;
    case (state)
      IDLE:    state_nx = accept ? LUT_REQ : IDLE;
      LUT_REQ: state_nx = LUT_CAP;
      LUT_CAP: begin
        state_nx = (bad || lt_len == '0) ? IDLE : STREAM;
        done_nx = bad || lt_len == '0;
        err_nx = bad;
      end
      STREAM:  state_nx = (mem_en && last_issue) ? DRAIN : STREAM;
      DRAIN: begin
        state_nx = (pop && os.out_last) ? IDLE : DRAIN;
        done_nx = pop && os.out_last;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      lt_addr <= '0;
      mem_addr <= '0;
      len_q <= '0;
      issue_cnt <= '0;
      beat_cnt <= '0;
      fifo <= '0;
      count <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      inflight <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= done_nx;
      err <= err_nx;
      inflight <= mem_en;
      count <= count + 2'(inflight) - 2'(pop);
      if (accept) lt_addr <= line;
      if (state == LUT_CAP) begin
        len_q <= lt_len;
        mem_addr <= lt_start;
        issue_cnt <= '0;
        beat_cnt <= '0;
      end
      if (mem_en) begin
        issue_cnt <= issue_cnt + LEN_W'(1);
        if (!last_issue) mem_addr <= mem_addr + ADDR_W'(1);
      end
      if (inflight) begin
        fifo[wr_ptr] <= mem_dout;
        wr_ptr <= !wr_ptr;
      end
      if (pop) begin
        rd_ptr <= !rd_ptr;
        beat_cnt <= beat_cnt + LEN_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_transform_stream_walker.sv
// tb_transform_stream_walker: scoreboard bench with table/memory models and randomized walks
module tb_transform_stream_walker;
  localparam int CW = 8, AW = 8, LW = 8, NW = 8, NL = 2;
  logic clk = 0, rst = 1, start = 0;
  logic [NW-1:0] line = '0;
  logic busy, mem_en, done, err;
  logic [NW-1:0] lt_addr;
  logic [LW+AW-1:0] lt_data;
  logic [AW-1:0] mem_addr;
  logic [2*CW-1:0] mem_dout;
  logic [15:0] mem [256];
  logic [15:0] lt [256];
  logic [16:0] exp_q [$];
  bit exp_err [$];
  int beat_cyc [$];
  int checks = 0, errors = 0, reads = 0, pops = 0, cyc = 0;
  bit rand_ready = 0, stall_prev = 0;
  logic [15:0] stall_data;
  transform_stream_walker_if #(.CHAR_W(CW)) os ();
  transform_stream_walker #(.CHAR_W(CW), .ADDR_W(AW), .LEN_W(LW), .LINE_W(NW), .NUM_LINES(NL)) dut (
    .clk(clk), .rst(rst), .start(start), .line(line), .busy(busy), .lt_addr(lt_addr),
    .lt_data(lt_data), .mem_en(mem_en), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .os(os), .done(done), .err(err));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    lt_data <= lt[lt_addr];
    if (mem_en) mem_dout <= mem[mem_addr];
  end
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, expv, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (rst) stall_prev = 0;
    else begin
      if (mem_en) reads++;
      if (os.out_valid && os.out_ready) begin
        pops++;
        beat_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got %0h expected no beat", {os.lhs, os.rhs});
        end else chk("beat", {os.lhs, os.rhs, os.out_last}, exp_q.pop_front());
      end
      if (stall_prev) chk("stall_hold", {os.out_valid, os.lhs, os.rhs}, {1'b1, stall_data});
      stall_prev = os.out_valid && !os.out_ready;
      stall_data = {os.lhs, os.rhs};
      chk("outstanding_le2", 64'((reads - pops) <= 2), 1);
      if (done) begin
        if (exp_err.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected 0");
        end else chk("done_err", err, exp_err.pop_front());
      end else if (err) chk("err_without_done", err, 0);
    end
  end
  initial forever begin
    @(posedge clk); #1;
    if (rand_ready) os.out_ready = $urandom_range(0, 3) != 0;
  end
  // reference: a walk yields mem[start..start+len-1] unless the line or range is illegal
  task automatic expect_walk(input int l, output int nrd, output logic [7:0] st);
    logic [7:0] ln;
    {ln, st} = lt[l];
    nrd = 0;
    if (l >= NL || int'(st) + int'(ln) > 256) exp_err.push_back(1);
    else begin
      for (int i = 0; i < int'(ln); i++) exp_q.push_back({mem[int'(st) + i], i == int'(ln) - 1});
      exp_err.push_back(0);
      nrd = ln;
    end
  endtask
  task automatic do_start(input int l, output int c0);
    @(posedge clk); #1;
    start = 1; line = 8'(l); c0 = cyc;
    @(posedge clk); #1;
    start = 0;
  endtask
  task automatic wait_done(output int dc);
    int n = 0;
    while (!done && n < 3000) begin @(posedge clk); #1; n++; end
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done expected done within 3000 cycles");
    end
    dc = cyc;
  endtask
  task automatic run_walk(input int l, output int c0, output int dc);
    int nrd, r0;
    logic [7:0] st;
    expect_walk(l, nrd, st);
    r0 = reads;
    do_start(l, c0);
    chk("lt_addr_busy", {busy, lt_addr}, {1'b1, 8'(l)});
    repeat (2) begin @(posedge clk); #1; end
    if (nrd > 0) chk("first_read", {mem_en, mem_addr}, {1'b1, st});
    else chk("early_done", {done, busy, mem_en}, 3'b100);
    wait_done(dc);
    chk("reads_issued", reads - r0, nrd);
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask
  initial begin
    int c0, dc, nrd;
    logic [7:0] st;
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int c0, dc, nrd;
    logic [7:0] st;
    os.out_ready = 1;
    for (int i = 0; i < 256; i++) begin mem[i] = 16'($urandom); lt[i] = 16'($urandom); end
    mem[0] = 16'h3131; mem[1] = 16'h3173; mem[2] = 16'h7320;
    repeat (3) @(posedge clk); #1;
    chk("reset_state", {busy, os.out_valid, mem_en, done, err, os.out_last, os.lhs, os.rhs, lt_addr, mem_addr}, 0);
    rst = 0;
    // basic 3-beat line at full rate
    lt[0] = {8'd3, 8'd0};
    beat_cyc.delete();
    run_walk(0, c0, dc);
    chk("t1_done_cycle", dc - c0, 8);
    chk("t1_beat_cycles", beat_cyc.size() == 3 ? {8'(beat_cyc[0] - c0), 8'(beat_cyc[1] - c0), 8'(beat_cyc[2] - c0)} : 24'h0, 24'h050607);
    // consumer stalls cycles 5-9
    fork
      run_walk(0, c0, dc);
      begin
        @(posedge clk);
        repeat (5) @(posedge clk); #1; os.out_ready = 0;
        repeat (4) @(posedge clk); #1;
        chk("t2_held_head", {os.out_valid, os.lhs, os.rhs}, {1'b1, 16'h3131});
        @(posedge clk); #1; os.out_ready = 1;
      end
    join
    chk("t2_done_cycle", dc - c0, 13);
    // illegal line index
    run_walk(2, c0, dc);
    chk("t3_done_cycle_busy", {8'(dc - c0), busy}, {8'd3, 1'b0});
    // range overflow, zero length, exact-fit boundaries
    lt[0] = {8'd4, 8'hFE}; run_walk(0, c0, dc);
    lt[0] = {8'd0, 8'h10}; run_walk(0, c0, dc);
    lt[1] = {8'd2, 8'hFE}; run_walk(1, c0, dc);
    lt[1] = {8'd255, 8'd2}; run_walk(1, c0, dc);
    lt[0] = {8'd255, 8'd1}; rand_ready = 1; run_walk(0, c0, dc);
    rand_ready = 0; os.out_ready = 1;
    // reset in the middle of a walk, then a fresh start in cycle 8
    lt[0] = {8'd5, 8'h20};
    expect_walk(0, nrd, st);
    do_start(0, c0);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("t5_after_rst", {os.out_valid, busy, mem_en, done}, 0);
    exp_q.delete(); exp_err.delete(); reads = 0; pops = 0;
    run_walk(0, c0, dc);
    chk("t5_restart_cycle", c0 - cyc + (dc - c0), 0);
    // starts during an active walk are ignored
    lt[0] = {8'd4, 8'h40}; lt[1] = {8'd3, 8'h80};
    fork
      run_walk(0, c0, dc);
      begin
        @(posedge clk);
        repeat (2) @(posedge clk); #1; start = 1; line = 1;
        @(posedge clk); #1; start = 0;
        @(posedge clk); #1; start = 1; line = 1;
        @(posedge clk); #1; start = 0;
      end
    join
    start = 1; line = 1;
    run_walk(0, c0, dc);
    // randomized walks with random backpressure
    rand_ready = 1;
    for (int k = 0; k < 25; k++) begin
      for (int j = 0; j < 2; j++)
        lt[j] = {8'($urandom_range(0, 10)), $urandom_range(0, 3) == 0 ? 8'(256 - $urandom_range(0, 12)) : 8'($urandom)};
      run_walk($urandom_range(0, 2), c0, dc);
    end
    rand_ready = 0; os.out_ready = 1;
    repeat (3) @(posedge clk);
    chk("final_idle", {busy, os.out_valid, 32'(exp_err.size())}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
